// File: rtl/nonce_collector_pkg.sv
// Shared types for the nonce collector slice.
//   NONCE_W           : width of one nonce
//   nonce_t           : one 32-bit nonce
//   collector_state_e : collector FSM states
package nonce_collector_pkg;

    localparam int NONCE_W = 32;

    typedef logic [NONCE_W-1:0] nonce_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        REPORT
    } collector_state_e;

endpackage

// File: rtl/nonce_collector_if.sv
// Lane-result and host-result bundle for nonce_collector.
//   newblock_i : start of a new block (lane side)
//   valid_i    : per-lane result valid
//   success_i  : per-lane hash-meets-target, qualified by valid_i
//   nonce_i    : per-lane nonce, lane k in bits [32k+31:32k]
//   ready_i    : host accepts the result
//   valid_o    : result available, held until accepted
//   success_o  : 1 = winning nonce, 0 = space exhausted
//   nonce_o    : winning nonce, 0 when success_o = 0
//   busy_o     : collector is searching
// master = upstream extractors plus host, slave = collector.
interface nonce_collector_if #(
    parameter int NUMPROCESSORS = 10
);
    import nonce_collector_pkg::*;

    logic                               newblock_i;
    logic [NUMPROCESSORS-1:0]           valid_i;
    logic [NUMPROCESSORS-1:0]           success_i;
    logic [NUMPROCESSORS*NONCE_W-1:0]   nonce_i;
    logic                               ready_i;
    logic                               valid_o;
    logic                               success_o;
    nonce_t                             nonce_o;
    logic                               busy_o;

    modport master (
        output newblock_i, valid_i, success_i, nonce_i, ready_i,
        input  valid_o, success_o, nonce_o, busy_o
    );

    modport slave (
        input  newblock_i, valid_i, success_i, nonce_i, ready_i,
        output valid_o, success_o, nonce_o, busy_o
    );

endinterface

// File: rtl/nonce_collector_lowest_set_picker.sv
// Finds the lowest-index set bit of a vector.
//   vec_i : input vector, N bits
//   any_o : at least one bit set
//   idx_o : index of the lowest set bit (0 when none set)
module lowest_set_picker #(
    parameter int N    = 10,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    vec_i,
    output logic            any_o,
    output logic [IDXW-1:0] idx_o
);

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec_i[i] && !any_o) begin
                any_o = 1'b1;
                idx_o = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/nonce_collector.sv
// Gathers per-lane extractor results for the current block, picks the
// lowest-index winning nonce or flags that the nonce space is exhausted,
// and offers one result per block to the host via valid/ready.
//   clk : system clock
//   rst : asynchronous active-high reset
//   nc  : lane inputs and host result (see nonce_collector_if)
module nonce_collector
    import nonce_collector_pkg::*;
#(
    parameter int NUMPROCESSORS = 10,
    parameter int NONCESPACE    = 64,
    parameter int COUNTW        = $clog2(NONCESPACE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    nonce_collector_if.slave  nc
);

    localparam int IDXW = (NUMPROCESSORS > 1) ? $clog2(NUMPROCESSORS) : 1;

    function automatic logic [COUNTW-1:0] popcount(input logic [NUMPROCESSORS-1:0] v);
        logic [COUNTW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NUMPROCESSORS; i++) begin
            c = c + COUNTW'(v[i]);
        end
        return c;
    endfunction

    collector_state_e          state;
    logic [COUNTW-1:0]         count;

    logic [NUMPROCESSORS-1:0]  hit;
    logic                      hit_any;
    logic [IDXW-1:0]           hit_idx;
    nonce_t                    lane_nonce [NUMPROCESSORS];
    nonce_t                    win_nonce;

    logic                      evaluate;
    logic [COUNTW-1:0]         base;
    logic [COUNTW:0]           sum;
    logic                      exhausted;
    logic [COUNTW-1:0]         next_count;

    assign hit = nc.valid_i & nc.success_i;

    lowest_set_picker #(
        .N    (NUMPROCESSORS),
        .IDXW (IDXW)
    ) u_picker (
        .vec_i (hit),
        .any_o (hit_any),
        .idx_o (hit_idx)
    );

    always_comb begin
        for (int unsigned k = 0; k < NUMPROCESSORS; k++) begin
            lane_nonce[k] = nc.nonce_i[k*NONCE_W +: NONCE_W];
        end
        win_nonce = lane_nonce[hit_idx];
    end

    // A new block restarts the count from zero but its first cycle goes
    // through the same success/exhaustion evaluation as any SEARCH cycle,
    // so reload and evaluation share one path via 'base'.
    always_comb begin
        evaluate   = nc.newblock_i || (state == SEARCH);
        base       = nc.newblock_i ? '0 : count;
        sum        = {1'b0, base} + {1'b0, popcount(nc.valid_i)};
        exhausted  = (sum >= (COUNTW+1)'(NONCESPACE));
        next_count = exhausted ? COUNTW'(NONCESPACE) : sum[COUNTW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            nc.valid_o   <= 1'b0;
            nc.success_o <= 1'b0;
            nc.nonce_o   <= '0;
            nc.busy_o    <= 1'b0;
        end else if (evaluate) begin
            count <= next_count;
            if (hit_any) begin
                state        <= REPORT;
                nc.valid_o   <= 1'b1;
                nc.success_o <= 1'b1;
                nc.nonce_o   <= win_nonce;
                nc.busy_o    <= 1'b0;
            end else if (exhausted) begin
                state        <= REPORT;
                nc.valid_o   <= 1'b1;
                nc.success_o <= 1'b0;
                nc.nonce_o   <= '0;
                nc.busy_o    <= 1'b0;
            end else begin
                // Also drops any pending result when a new block aborts REPORT.
                state        <= SEARCH;
                nc.valid_o   <= 1'b0;
                nc.success_o <= 1'b0;
                nc.nonce_o   <= '0;
                nc.busy_o    <= 1'b1;
            end
        end else if ((state == REPORT) && nc.ready_i) begin
            state        <= IDLE;
            nc.valid_o   <= 1'b0;
            nc.success_o <= 1'b0;
            nc.nonce_o   <= '0;
            nc.busy_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nonce_collector.sv
// Directed testbench for nonce_collector (10 lanes, 64-nonce space).
module tb_nonce_collector;
    import nonce_collector_pkg::*;

    localparam int NP = 10;
    localparam logic [NP-1:0] ALL  = 10'h3FF;
    localparam logic [NP-1:0] LOW3 = 10'h007;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    nonce_collector_if #(.NUMPROCESSORS(NP)) nc ();

    nonce_collector #(
        .NUMPROCESSORS (NP),
        .NONCESPACE    (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .nc  (nc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nonce(input int lane, input logic [31:0] v);
        nc.nonce_i[lane*32 +: 32] = v;
    endtask

    task automatic fill_nonces(input logic [31:0] seed);
        for (int k = 0; k < NP; k++) set_nonce(k, seed + 32'(k));
    endtask

    task automatic lanes(input logic nb, input logic [NP-1:0] v, input logic [NP-1:0] s);
        nc.newblock_i = nb;
        nc.valid_i    = v;
        nc.success_i  = s;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic s,
                              input logic [31:0] n, input logic b);
        check({tag, ".valid"},   32'(nc.valid_o),   32'(v));
        check({tag, ".success"}, 32'(nc.success_o), 32'(s));
        check({tag, ".nonce"},   nc.nonce_o,        n);
        check({tag, ".busy"},    32'(nc.busy_o),    32'(b));
    endtask

    task automatic accept(input string tag);
        nc.ready_i = 1'b1;
        lanes(1'b0, '0, '0);
        tick();
        nc.ready_i = 1'b0;
        expect_out(tag, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        nc.ready_i = 1'b0;
        lanes(1'b0, '0, '0);
        fill_nonces(32'h100);
        #1;
        expect_out("reset", 1'b0, 1'b0, 32'h0, 1'b0);

        // Random lane traffic without newblock, across reset release.
        for (int i = 0; i < 6; i++) begin
            lanes(1'b0, NP'($urandom), NP'($urandom));
            fill_nonces($urandom);
            if (i == 2) rst = 1'b0;
            tick();
            check("idle.valid", 32'(nc.valid_o), 32'h0);
            check("idle.busy",  32'(nc.busy_o),  32'h0);
        end

        // Single winner on cycle 3, held 5 cycles with late successes ignored.
        fill_nonces(32'h100);
        set_nonce(4, 32'h2A);
        lanes(1'b1, ALL, '0);
        tick();
        expect_out("win.c1", 1'b0, 1'b0, 32'h0, 1'b1);
        lanes(1'b0, ALL, '0);
        tick();
        expect_out("win.c2", 1'b0, 1'b0, 32'h0, 1'b1);
        lanes(1'b0, ALL, 10'h010);
        tick();
        expect_out("win.rep", 1'b1, 1'b1, 32'h2A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            lanes(1'b0, ALL, ALL);
            set_nonce(0, 32'hDEAD0000 + 32'(i));
            tick();
            expect_out("win.hold", 1'b1, 1'b1, 32'h2A, 1'b0);
        end
        accept("win.acc");

        // Priority: lanes 7 and 2 hit; lane 1 claims success but is not valid.
        fill_nonces(32'h200);
        set_nonce(7, 32'h33);
        set_nonce(2, 32'h15);
        set_nonce(1, 32'h99);
        lanes(1'b1, ALL, '0);
        tick();
        lanes(1'b0, ALL & ~10'h002, 10'h086);
        tick();
        expect_out("prio", 1'b1, 1'b1, 32'h15, 1'b0);
        accept("prio.acc");

        // Hit on the newblock cycle itself.
        set_nonce(9, 32'h77);
        lanes(1'b1, ALL, 10'h200);
        tick();
        expect_out("nbhit", 1'b1, 1'b1, 32'h77, 1'b0);
        accept("nbhit.acc");

        // Exhaustion, 10 lanes per cycle: 60 after 6 cycles, 70->64 on the 7th.
        fill_nonces(32'h300);
        lanes(1'b1, ALL, '0);
        tick();
        lanes(1'b0, ALL, '0);
        for (int i = 2; i <= 6; i++) tick();
        expect_out("exh10.c6", 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        expect_out("exh10.rep", 1'b1, 1'b0, 32'h0, 1'b0);
        accept("exh10.acc");

        // Exhaustion, 3 lanes per cycle: 63 on cycle 21, 66->64 on cycle 22.
        lanes(1'b1, LOW3, '0);
        tick();
        lanes(1'b0, LOW3, '0);
        for (int i = 2; i <= 21; i++) tick();
        expect_out("exh3.c21", 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        expect_out("exh3.rep", 1'b1, 1'b0, 32'h0, 1'b0);
        accept("exh3.acc");

        // Tie: the crossing cycle also hits lane 0; success wins.
        set_nonce(0, 32'h3F);
        lanes(1'b1, ALL, '0);
        tick();
        lanes(1'b0, ALL, '0);
        for (int i = 2; i <= 6; i++) tick();
        lanes(1'b0, ALL, 10'h001);
        tick();
        expect_out("tie", 1'b1, 1'b1, 32'h3F, 1'b0);

        // Abort from REPORT: count restarts at 3, so 6 full cycles give 63.
        lanes(1'b1, LOW3, '0);
        tick();
        expect_out("abrep", 1'b0, 1'b0, 32'h0, 1'b1);
        lanes(1'b0, ALL, '0);
        for (int i = 0; i < 6; i++) tick();
        expect_out("abrep.63", 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        expect_out("abrep.rep", 1'b1, 1'b0, 32'h0, 1'b0);
        accept("abrep.acc");

        // Abort from SEARCH at count 40: restart at 3.
        lanes(1'b1, ALL, '0);
        tick();
        lanes(1'b0, ALL, '0);
        for (int i = 0; i < 3; i++) tick();
        lanes(1'b1, LOW3, '0);
        tick();
        expect_out("absrch", 1'b0, 1'b0, 32'h0, 1'b1);
        lanes(1'b0, ALL, '0);
        for (int i = 0; i < 6; i++) tick();
        expect_out("absrch.63", 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        expect_out("absrch.rep", 1'b1, 1'b0, 32'h0, 1'b0);
        accept("absrch.acc");

        // Async reset mid-SEARCH, checked between clock edges.
        lanes(1'b1, ALL, '0);
        tick();
        lanes(1'b0, ALL, '0);
        tick();
        check("pre_rst.busy", 32'(nc.busy_o), 32'h1);
        #1 rst = 1'b1;
        #1;
        expect_out("arst.search", 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;

        // Async reset mid-REPORT.
        set_nonce(5, 32'hABCD);
        lanes(1'b1, ALL, 10'h020);
        tick();
        expect_out("pre_rst.rep", 1'b1, 1'b1, 32'hABCD, 1'b0);
        #1 rst = 1'b1;
        #1;
        expect_out("arst.report", 1'b0, 1'b0, 32'h0, 1'b0);
        lanes(1'b0, '0, '0);
        tick();
        rst = 1'b0;
        tick();
        expect_out("post_rst", 1'b0, 1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
